// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint sequencer: turns board-clock events into a one-cycle CPU execute strobe.
// The breakpoint compare, skip flag and BREAK state are built only with CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BASE_DIV        = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run_switch,
   input  logic       step_button,
   input  logic [1:0] speed,
   input  logic [3:0] pc,
   input  logic [3:0] bp_addr,
   input  logic       bp_enable,
   output logic       cpu_enable,
   output logic       halted,
   output logic       at_break,
   output logic [7:0] step_count
);

   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TICK_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

   // Per-speed dividers, clamped so that a divider of 1 ticks every cycle.
   localparam int DIV0 = (BASE_DIV < 1)        ? 1 : BASE_DIV;
   localparam int DIV1 = ((BASE_DIV >> 2) < 1) ? 1 : (BASE_DIV >> 2);
   localparam int DIV2 = ((BASE_DIV >> 4) < 1) ? 1 : (BASE_DIV >> 4);
   localparam int DIV3 = ((BASE_DIV >> 6) < 1) ? 1 : (BASE_DIV >> 6);

   typedef enum logic [1:0] {
      S_HALT  = 2'd0,
      S_RUN   = 2'd1,
      S_BREAK = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_enable_next;

   logic [1:0]        r_sync;
   logic [DB_W-1:0]   r_db_cnt;
   logic              r_stable;
   logic              r_step_pulse;

   logic [TICK_W-1:0] r_tick_cnt;
   logic [TICK_W-1:0] w_div_m1;
   logic [1:0]        r_speed;
   logic              w_speed_change;
   logic              w_tick;

   logic              w_bp_hit;
   logic              r_cpu_enable;
   logic              r_halted;
   logic [7:0]        r_step_count;

   // Button path: 2-FF synchroniser, then a level that flips only after it has
   // disagreed with the synchronised input for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync       <= 2'b00;
         r_db_cnt     <= '0;
         r_stable     <= 1'b0;
         r_step_pulse <= 1'b0;
      end else begin
         r_sync       <= {r_sync[0], step_button};
         r_step_pulse <= 1'b0;
         if (r_sync[1] == r_stable) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db_cnt     <= '0;
            r_stable     <= ~r_stable;
            r_step_pulse <= ~r_stable;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      case (speed)
         2'd0:    w_div_m1 = TICK_W'(DIV0 - 1);
         2'd1:    w_div_m1 = TICK_W'(DIV1 - 1);
         2'd2:    w_div_m1 = TICK_W'(DIV2 - 1);
         default: w_div_m1 = TICK_W'(DIV3 - 1);
      endcase
   end

   // A speed change restarts the rate period instead of letting a stale count tick early.
   assign w_speed_change = (speed != r_speed);
   assign w_tick         = (r_state == S_RUN) && !w_speed_change && (r_tick_cnt == w_div_m1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tick_cnt <= '0;
         r_speed    <= 2'd0;
      end else begin
         r_speed <= speed;
         if ((r_state != S_RUN) || w_speed_change || w_tick) begin
            r_tick_cnt <= '0;
         end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end
      end
   end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
   logic r_skip;
   logic r_at_break;

   // Skip lets the CPU execute the breakpoint instruction once after a resume.
   assign w_bp_hit = bp_enable && (pc == bp_addr) && !r_skip;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_skip     <= 1'b0;
         r_at_break <= 1'b0;
      end else begin
         r_at_break <= (w_state_next == S_BREAK);
         if ((r_state == S_BREAK) && (w_state_next != S_BREAK)) begin
            r_skip <= 1'b1;
         end else if (r_cpu_enable) begin
            r_skip <= 1'b0;
         end
      end
   end

   assign at_break = r_at_break;
`else
   logic w_unused_bp;
   assign w_unused_bp = ^{pc, bp_addr, bp_enable};
   assign w_bp_hit    = 1'b0;
   assign at_break    = 1'b0;
`endif

   always_comb begin
      w_state_next  = r_state;
      w_enable_next = 1'b0;
      case (r_state)
         S_HALT: begin
            if (run_switch) begin
               w_state_next = S_RUN;
            end else if (r_step_pulse) begin
               w_enable_next = 1'b1;
            end
         end
         S_RUN: begin
            if (!run_switch) begin
               w_state_next = S_HALT;
            end else if (w_bp_hit) begin
               w_state_next = S_BREAK;
            end else begin
               w_enable_next = w_tick;
            end
         end
         S_BREAK: begin
            if (!run_switch) begin
               w_state_next = S_HALT;
            end else if (r_step_pulse) begin
               w_enable_next = 1'b1;
               w_state_next  = S_RUN;
            end
         end
         default: w_state_next = S_HALT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_HALT;
         r_cpu_enable <= 1'b0;
         r_halted     <= 1'b1;
         r_step_count <= 8'd0;
      end else begin
         r_state      <= w_state_next;
         r_cpu_enable <= w_enable_next;
         r_halted     <= (w_state_next != S_RUN);
         if (r_cpu_enable) begin
            r_step_count <= r_step_count + 8'd1;
         end
      end
   end

   assign cpu_enable = r_cpu_enable;
   assign halted     = r_halted;
   assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller (DEBOUNCE_CYCLES=4, BASE_DIV=64); expectations come
// from the rate/debounce/breakpoint rules evaluated per cycle index with plain arithmetic.
module tb_cpu_run_controller;

   localparam int DB = 4;
   localparam int BD = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       run_switch = 1'b0;
   logic       step_button = 1'b0;
   logic [1:0] speed = 2'd0;
   logic [3:0] pc;
   logic [3:0] bp_addr = 4'd0;
   logic       bp_enable = 1'b0;
   logic       cpu_enable;
   logic       halted;
   logic       at_break;
   logic [7:0] step_count;

   logic        pc_follow = 1'b0;
   logic [10:0] obs;
   logic [10:0] exp_v;
   logic [7:0]  model_count;
   int          n_checks = 0;
   int          n_fail = 0;

   assign pc  = pc_follow ? step_count[3:0] : 4'd0;
   assign obs = {cpu_enable, halted, at_break, step_count};

   cpu_run_controller #(
      .DEBOUNCE_CYCLES(DB),
      .BASE_DIV       (BD)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .run_switch (run_switch),
      .step_button(step_button),
      .speed      (speed),
      .pc         (pc),
      .bp_addr    (bp_addr),
      .bp_enable  (bp_enable),
      .cpu_enable (cpu_enable),
      .halted     (halted),
      .at_break   (at_break),
      .step_count (step_count)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one edge and settle; outputs are sampled 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      run_switch = 1'b0;
      step_button = 1'b0;
      cyc();
      cyc();
      model_count = 8'd0;
      n_checks++;
      if (obs !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_values: got en/halt/brk/cnt=%b want %b", obs, {1'b0, 1'b1, 1'b0, 8'd0});
      end
      reset = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         cyc();
         exp_v = {1'b0, 1'b1, 1'b0, model_count};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_halt n=%0d: got %b want %b", n, obs, exp_v);
         end
      end
      $display("test_reset: done, step_count=%0d", step_count);
   endtask

   // Bouncy press 1,0,1 then high until cycle 13; the final rising run starts at cycle 3,
   // so the debounced level flips DB+1 edges after the 2-stage sync and the enable lands one later.
   task automatic test_step();
      logic exp_en;
      for (int n = 1; n <= 60; n++) begin
         step_button = (n == 1) || (n >= 3 && n <= 13);
         cyc();
         exp_en = (n == 3 + DB + 2);
         exp_v  = {exp_en, 1'b1, 1'b0, model_count};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL step_press n=%0d: got %b want %b", n, obs, exp_v);
         end
         if (exp_en) model_count++;
      end
      step_button = 1'b0;
      $display("test_step: done, step_count=%0d", step_count);
   endtask

   task automatic test_free_run();
      logic exp_en;
      speed = 2'd0;
      cyc();
      run_switch = 1'b1;
      for (int n = 1; n <= 941; n++) begin
         if (n == 642) speed = 2'd3;
         cyc();
         if (n <= 641) exp_en = (n > 1) && ((n - 1) % BD == 0);
         else          exp_en = (n >= 643);
         exp_v = {exp_en, 1'b0, 1'b0, model_count};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL free_run n=%0d speed=%0d: got %b want %b", n, speed, obs, exp_v);
         end
         if (exp_en) model_count++;
      end
      // At div=1 every cycle ticks, so this drop coincides with a tick.
      run_switch = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         cyc();
         exp_v = {1'b0, 1'b1, 1'b0, model_count};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL drop_on_tick n=%0d: got %b want %b", n, obs, exp_v);
         end
      end
      $display("test_free_run: done, step_count=%0d", step_count);
   endtask

   task automatic test_random_runs();
      int   sp, div, j, extra, len;
      logic exp_en;
      for (int it = 0; it < 8; it++) begin
         sp  = $urandom_range(3, 1);
         div = BD >> (2 * sp);
         if (div < 1) div = 1;
         j     = $urandom_range(4, 1);
         extra = ((div > 1) && ($urandom_range(1, 0) == 1)) ? $urandom_range(div - 1, 1) : 0;
         len   = j * div + extra;
         speed = 2'(sp);
         cyc();
         run_switch = 1'b1;
         for (int n = 1; n <= len + 6; n++) begin
            if (n == len + 1) run_switch = 1'b0;
            cyc();
            exp_en = (n <= len) && (n > 1) && ((n - 1) % div == 0);
            exp_v  = {exp_en, (n > len), 1'b0, model_count};
            n_checks++;
            if (obs !== exp_v) begin
               n_fail++;
               $display("FAIL random_run it=%0d div=%0d len=%0d n=%0d: got %b want %b",
                        it, div, len, n, obs, exp_v);
            end
            if (exp_en) model_count++;
         end
         $display("random_run %0d: div=%0d len=%0d step_count=%0d", it, div, len, step_count);
      end
   endtask

   task automatic test_breakpoint();
      int   div, b_edge, r_press, r_edge, n_end;
      logic exp_en, exp_brk, exp_halt;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      model_count = 8'd0;
      div       = BD >> 4;
      speed     = 2'd2;
      bp_addr   = 4'd5;
      bp_enable = 1'b1;
      pc_follow = 1'b1;
      cyc();
      run_switch = 1'b1;
      // pc reaches 5 one edge after the 5th enable; BREAK is registered one edge later.
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      b_edge = 5 * div + 3;
`else
      b_edge = 0;
`endif
      r_press = 5 * div + 13;
      r_edge  = r_press + DB + 2;
      n_end   = r_edge + 40;
      for (int n = 1; n <= n_end + 4; n++) begin
         step_button = (n >= r_press) && (n < r_press + 10);
         if (n == n_end + 1) run_switch = 1'b0;
         cyc();
         if (b_edge == 0) begin
            exp_brk = 1'b0;
            exp_en  = (n <= n_end) && (n > 1) && ((n - 1) % div == 0);
         end else begin
            exp_brk = (n >= b_edge) && (n < r_edge);
            if (n < b_edge)       exp_en = (n > 1) && ((n - 1) % div == 0);
            else if (n < r_edge)  exp_en = 1'b0;
            else                  exp_en = (n <= n_end) && ((n - r_edge) % div == 0);
         end
         exp_halt = exp_brk || (n > n_end);
         exp_v    = {exp_en, exp_halt, exp_brk, model_count};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL breakpoint n=%0d pc=%0d: got %b want %b", n, pc, obs, exp_v);
         end
         if (exp_en) model_count++;
      end
      pc_follow = 1'b0;
      bp_enable = 1'b0;
      step_button = 1'b0;
      $display("test_breakpoint: done, step_count=%0d", step_count);
   endtask

   task automatic test_reset_mid_run();
      logic exp_en;
      speed = 2'd3;
      cyc();
      run_switch = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         step_button = (n >= 18);
         cyc();
         exp_en = (n >= 2);
         exp_v  = {exp_en, 1'b0, 1'b0, model_count};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset_run n=%0d: got %b want %b", n, obs, exp_v);
         end
         if (exp_en) model_count++;
      end
      reset = 1'b1;
      run_switch = 1'b0;
      step_button = 1'b0;
      cyc();
      model_count = 8'd0;
      n_checks++;
      if (obs !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL mid_run_reset: got %b want %b", obs, {1'b0, 1'b1, 1'b0, 8'd0});
      end
      reset = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         cyc();
         exp_v = {1'b0, 1'b1, 1'b0, model_count};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset n=%0d: got %b want %b", n, obs, exp_v);
         end
      end
      $display("test_reset_mid_run: done, step_count=%0d", step_count);
   endtask

   initial begin
      model_count = 8'd0;
      test_reset();
      test_step();
      test_free_run();
      test_random_runs();
      test_breakpoint();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
